// File: rtl/led_pattern_gen_if.sv
// Bundle between the board switches and the LED pattern engine.
// Master drives run/mode/speed; slave returns led and step_pulse.
interface led_pattern_gen_if #(
    parameter int N_LED = 8
);
    logic             run;
    logic [1:0]       mode;
    logic [1:0]       speed;
    logic [N_LED-1:0] led;
    logic             step_pulse;

    modport master (
        output run,
        output mode,
        output speed,
        input  led,
        input  step_pulse
    );

    modport slave (
        input  run,
        input  mode,
        input  speed,
        output led,
        output step_pulse
    );
endinterface

// File: rtl/led_pattern_gen.sv
// LED pattern engine: rotate-left/right, ping-pong and bar-fill on N_LED pins.
// Ports: clk_50, rst_n (async, active-low), bus (slave: run/mode/speed in, led/step_pulse out).
module led_pattern_gen #(
    parameter int N_LED          = 8,
    parameter int STEP_CYCLES    = 25000000,
    parameter bit LED_ACTIVE_LOW = 1'b1
) (
    input  logic              clk_50,
    input  logic              rst_n,
    led_pattern_gen_if.slave  bus
);

    localparam int CW = $clog2(STEP_CYCLES);

    localparam logic [N_LED-1:0] LED_MASK  = {N_LED{LED_ACTIVE_LOW}};
    localparam logic [N_LED-1:0] START_MSB = {1'b1, {(N_LED-1){1'b0}}};
    localparam logic [N_LED-1:0] START_LSB = {{(N_LED-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        M_ROT_L = 2'd0,
        M_ROT_R = 2'd1,
        M_PING  = 2'd2,
        M_BAR   = 2'd3
    } mode_e;

    mode_e            mode_q, mode_d, mode_in;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic [N_LED-1:0] pat_q, pat_d;
    logic [N_LED-1:0] led_q, led_d;
    logic             step_q, step_d;

    logic [31:0]      period;
    logic             tc;
    logic             one_hot;

    function automatic logic [N_LED-1:0] start_pat(mode_e m);
        logic [N_LED-1:0] r;
        r = '0;
        unique case (m)
            M_ROT_L: r = START_MSB;
            M_ROT_R: r = START_LSB;
            M_PING:  r = START_LSB;
            M_BAR:   r = '0;
        endcase
        return r;
    endfunction

    always_comb begin
        mode_in = mode_e'(bus.mode);
        // >= rather than == so a shorter period mid-count steps at once
        period  = 32'(STEP_CYCLES) >> bus.speed;
        tc      = bus.run &&
                  ({{(32-CW){1'b0}}, cnt_q} >= (period - 32'd1));
        one_hot = (pat_q != '0) &&
                  ((pat_q & (pat_q - START_LSB)) == '0);

        mode_d = mode_q;
        cnt_d  = cnt_q;
        dir_d  = dir_q;
        pat_d  = pat_q;
        step_d = 1'b0;

        if (mode_in != mode_q) begin
            // reload wins; a coincident terminal count is dropped
            mode_d = mode_in;
            cnt_d  = '0;
            dir_d  = 1'b0;
            pat_d  = start_pat(mode_in);
        end else if (tc) begin
            cnt_d  = '0;
            step_d = 1'b1;
            unique case (mode_q)
                M_ROT_L: begin
                    if (one_hot)
                        pat_d = {pat_q[N_LED-2:0], pat_q[N_LED-1]};
                    else
                        pat_d = start_pat(mode_q);
                end
                M_ROT_R: begin
                    if (one_hot)
                        pat_d = {pat_q[0], pat_q[N_LED-1:1]};
                    else
                        pat_d = start_pat(mode_q);
                end
                M_PING: begin
                    if (!one_hot) begin
                        pat_d = start_pat(mode_q);
                        dir_d = 1'b0;
                    end else begin
                        if (!dir_q)
                            pat_d = pat_q << 1;
                        else
                            pat_d = pat_q >> 1;
                        // turn around on arrival so endpoints show once
                        if (pat_d[N_LED-1])
                            dir_d = 1'b1;
                        else if (pat_d[0])
                            dir_d = 1'b0;
                    end
                end
                M_BAR: begin
                    if (&pat_q)
                        pat_d = '0;
                    else
                        pat_d = {pat_q[N_LED-2:0], 1'b1};
                end
            endcase
        end else if (bus.run) begin
            cnt_d = cnt_q + CW'(1);
        end

        led_d = pat_d ^ LED_MASK;
    end

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= M_ROT_L;
            cnt_q  <= '0;
            dir_q  <= 1'b0;
            pat_q  <= START_MSB;
            led_q  <= START_MSB ^ LED_MASK;
            step_q <= 1'b0;
        end else begin
            mode_q <= mode_d;
            cnt_q  <= cnt_d;
            dir_q  <= dir_d;
            pat_q  <= pat_d;
            led_q  <= led_d;
            step_q <= step_d;
        end
    end

    assign bus.led        = led_q;
    assign bus.step_pulse = step_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Bench for led_pattern_gen: directed scenarios then random switch activity.
// Expected LED images come from a step-index model of each pattern.
module tb_led_pattern_gen;

    localparam int N  = 8;
    localparam int SC = 8;

    logic clk_50 = 1'b0;
    logic rst_n  = 1'b0;

    always #10 clk_50 = ~clk_50;

    led_pattern_gen_if #(.N_LED(N)) bus();

    led_pattern_gen #(
        .N_LED          (N),
        .STEP_CYCLES    (SC),
        .LED_ACTIVE_LOW (1'b1)
    ) dut (
        .clk_50 (clk_50),
        .rst_n  (rst_n),
        .bus    (bus.slave)
    );

    int   checks = 0;
    int   errors = 0;

    // model: current mode, steps taken since reload, cycles since last step
    int   m_mode;
    int   m_k;
    int   m_cnt;
    logic m_step;

    function automatic logic [N-1:0] pat_of(int md, int k);
        logic [N-1:0] r;
        int p;
        r = '0;
        case (md)
            0: r[(N - 1 + k) % N] = 1'b1;
            1: r[(N - (k % N)) % N] = 1'b1;
            2: begin
                p = k % (2 * N - 2);
                r[(p < N) ? p : (2 * N - 2 - p)] = 1'b1;
            end
            default: begin
                p = k % (N + 1);
                r = N'((1 << p) - 1);
            end
        endcase
        return r;
    endfunction

    function automatic logic [N-1:0] exp_led();
        return ~pat_of(m_mode, m_k);
    endfunction

    task automatic model_reset();
        m_mode = 0;
        m_k    = 0;
        m_cnt  = 0;
        m_step = 1'b0;
    endtask

    task automatic model_edge();
        int p;
        if (!rst_n) begin
            model_reset();
        end else if (int'(bus.mode) != m_mode) begin
            m_mode = int'(bus.mode);
            m_k    = 0;
            m_cnt  = 0;
            m_step = 1'b0;
        end else begin
            p = SC >> bus.speed;
            if (bus.run && m_cnt >= p - 1) begin
                m_cnt  = 0;
                m_k    = m_k + 1;
                m_step = 1'b1;
            end else begin
                if (bus.run) m_cnt = m_cnt + 1;
                m_step = 1'b0;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_50);
        model_edge();
        #1;
        chk("led", 32'(bus.led), 32'(exp_led()));
        chk("step_pulse", 32'(bus.step_pulse), 32'(m_step));
    endtask

    initial begin
        int first;
        int gap;
        logic [N-1:0] saved;
        bit ok;

        bus.run   = 1'b1;
        bus.mode  = 2'd0;
        bus.speed = 2'd0;
        model_reset();

        repeat (3) cyc();
        chk("reset_led", 32'(bus.led), 32'h7F);
        rst_n = 1'b1;

        first = 0;
        for (int i = 1; i <= 20 && first == 0; i++) begin
            cyc();
            if (bus.step_pulse) first = i;
        end
        chk("first_step", first, 8);
        chk("first_led", 32'(bus.led), 32'hFE);

        repeat (56) cyc();
        chk("rotl_wrap", 32'(bus.led), 32'h7F);

        for (int s = 1; s <= 3; s++) begin
            bus.speed = 2'(s);
            repeat (24) cyc();
        end

        bus.speed = 2'd0;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            cyc();
            if (m_cnt == 5) ok = 1'b1;
        end
        chk("wait_cnt5", 32'(ok), 1);
        bus.speed = 2'd3;
        cyc();
        chk("speed_jump", 32'(bus.step_pulse), 1);
        cyc();
        chk("speed_every", 32'(bus.step_pulse), 1);

        bus.mode  = 2'd2;
        bus.speed = 2'd0;
        cyc();
        chk("pp_start", 32'(bus.led), 32'hFE);
        bus.speed = 2'd3;
        repeat (14) cyc();
        chk("pp_period", 32'(bus.led), 32'hFE);
        repeat (20) cyc();

        bus.mode = 2'd3;
        cyc();
        chk("bar_start", 32'(bus.led), 32'hFF);
        repeat (8) cyc();
        chk("bar_full", 32'(bus.led), 32'h00);
        cyc();
        chk("bar_wrap", 32'(bus.led), 32'hFF);

        bus.mode  = 2'd0;
        bus.speed = 2'd0;
        cyc();
        repeat (11) cyc();
        saved   = bus.led;
        bus.run = 1'b0;
        repeat (20) cyc();
        chk("pause_led", 32'(bus.led), 32'(saved));
        bus.run = 1'b1;

        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            cyc();
            if (m_cnt == SC - 1) ok = 1'b1;
        end
        chk("wait_tc", 32'(ok), 1);
        bus.mode = 2'd1;
        cyc();
        chk("tc_reload_led", 32'(bus.led), 32'hFE);
        chk("tc_reload_pulse", 32'(bus.step_pulse), 0);
        gap = 0;
        for (int i = 1; i <= 20 && gap == 0; i++) begin
            cyc();
            if (bus.step_pulse) gap = i;
        end
        chk("reload_gap", gap, 8);

        bus.mode  = 2'd2;
        bus.speed = 2'd3;
        cyc();
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            cyc();
            if ((m_k % 14) >= 8) ok = 1'b1;
        end
        chk("wait_dir_down", 32'(ok), 1);
        #4;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_rst_led", 32'(bus.led), 32'h7F);
        chk("async_rst_pulse", 32'(bus.step_pulse), 0);
        cyc();
        rst_n = 1'b1;
        cyc();
        chk("rst_reload", 32'(bus.led), 32'hFE);
        cyc();
        chk("rst_dir_up", 32'(bus.led), 32'hFD);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) bus.mode = 2'($urandom);
            if ($urandom_range(0, 19) == 0) bus.speed = 2'($urandom);
            if ($urandom_range(0, 9) == 0)
                bus.run = ($urandom_range(0, 3) != 0);
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
